// File: rtl/cve2_mem_arbiter.sv
// cve2_mem_arbiter
//   Shares one OBI-style memory port between the instruction-fetch and LSU
//   interfaces of the core. It picks one requester per cycle and holds that
//   choice while the downstream grant is pending. It also keeps an in-order
//   FIFO of source tags, so each mem_rvalid_i is routed back to the requester
//   that issued the transaction.
//
// Ports
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   instr_req_i / instr_addr_i    fetch request channel
//   instr_gnt_o                   fetch grant (same cycle as mem_gnt_i)
//   instr_rvalid_o/rdata_o/err_o  fetch response channel
//   data_req_i/we_i/be_i/addr_i/wdata_i  LSU request channel
//   data_gnt_o                    LSU grant
//   data_rvalid_o/rdata_o/err_o   LSU response channel
//   mem_req_o/we_o/be_o/addr_o/wdata_o   downstream request channel
//   mem_gnt_i                     downstream grant
//   mem_rvalid_i/rdata_i/err_i    downstream in-order response channel
//   outstanding_o                 granted-but-unanswered transaction count
module cve2_mem_arbiter #(
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned StarveLimit    = 4
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  instr_req_i,
  input  logic [31:0]                           instr_addr_i,
  output logic                                  instr_gnt_o,
  output logic                                  instr_rvalid_o,
  output logic [31:0]                           instr_rdata_o,
  output logic                                  instr_err_o,
  input  logic                                  data_req_i,
  input  logic                                  data_we_i,
  input  logic [3:0]                            data_be_i,
  input  logic [31:0]                           data_addr_i,
  input  logic [31:0]                           data_wdata_i,
  output logic                                  data_gnt_o,
  output logic                                  data_rvalid_o,
  output logic [31:0]                           data_rdata_o,
  output logic                                  data_err_o,
  output logic                                  mem_req_o,
  output logic                                  mem_we_o,
  output logic [3:0]                            mem_be_o,
  output logic [31:0]                           mem_addr_o,
  output logic [31:0]                           mem_wdata_o,
  input  logic                                  mem_gnt_i,
  input  logic                                  mem_rvalid_i,
  input  logic [31:0]                           mem_rdata_i,
  input  logic                                  mem_err_i,
  output logic [$clog2(MaxOutstanding+1)-1:0]   outstanding_o
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned StvW = (StarveLimit > 0) ? $clog2(StarveLimit + 1) : 1;
  localparam int unsigned TagDepth = 2 ** PtrW;

  localparam logic [CntW-1:0] CntFull = CntW'(MaxOutstanding);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(MaxOutstanding - 1);
  localparam logic [StvW-1:0] StvMax  = StvW'(StarveLimit);

  typedef enum logic {
    SrcInstr = 1'b0,
    SrcData  = 1'b1
  } src_e;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  src_e            tag_q [TagDepth];
  logic            lock_valid_q, lock_valid_d;
  src_e            lock_src_q, lock_src_d;
  logic [StvW-1:0] starve_q, starve_d;

  logic req_any, sel_data, issue, fifo_empty, pop, head_data;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrLast) ? '0 : p + 1'b1;
  endfunction

  // Request selection. A pending lock pins the source so the downstream
  // request fields cannot change while mem_req_o waits for its grant.
  // Otherwise data wins unless instr has waited StarveLimit cycles.
  always_comb begin
    sel_data = 1'b0;
    if (lock_valid_q) begin
      sel_data = (lock_src_q == SrcData);
    end else if (data_req_i && (!instr_req_i || (starve_q < StvMax))) begin
      sel_data = 1'b1;
    end
  end

  assign req_any    = instr_req_i | data_req_i;
  // A full FIFO blocks issue even if a pop happens in the same cycle.
  assign mem_req_o  = req_any && (cnt_q != CntFull);
  assign issue      = mem_req_o & mem_gnt_i;
  assign instr_gnt_o = issue & ~sel_data;
  assign data_gnt_o  = issue & sel_data;

  // Fields are zeroed when nobody requests so the idle port is all-zero.
  assign mem_we_o    = req_any & sel_data & data_we_i;
  assign mem_be_o    = !req_any ? 4'h0  : (sel_data ? data_be_i   : 4'hF);
  assign mem_addr_o  = !req_any ? 32'h0 : (sel_data ? data_addr_i : instr_addr_i);
  assign mem_wdata_o = (req_any & sel_data) ? data_wdata_i : 32'h0;

  // A response with no tag (e.g. one that arrives late after a reset) is dropped.
  assign fifo_empty = (cnt_q == '0);
  assign pop        = mem_rvalid_i & ~fifo_empty;
  assign head_data  = (tag_q[rd_ptr_q] == SrcData);

  assign instr_rvalid_o = pop & ~head_data;
  assign data_rvalid_o  = pop & head_data;
  assign instr_err_o    = instr_rvalid_o & mem_err_i;
  assign data_err_o     = data_rvalid_o & mem_err_i;
  assign instr_rdata_o  = mem_rvalid_i ? mem_rdata_i : 32'h0;
  assign data_rdata_o   = mem_rvalid_i ? mem_rdata_i : 32'h0;
  assign outstanding_o  = cnt_q;

  always_comb begin
    cnt_d        = cnt_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    lock_valid_d = lock_valid_q;
    lock_src_d   = lock_src_q;
    starve_d     = starve_q;

    if (issue) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)   rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({issue, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    if (issue) begin
      lock_valid_d = 1'b0;
    end else if (mem_req_o) begin
      lock_valid_d = 1'b1;
      lock_src_d   = sel_data ? SrcData : SrcInstr;
    end

    if (!instr_req_i || instr_gnt_o) begin
      starve_d = '0;
    end else if (starve_q < StvMax) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      lock_valid_q <= 1'b0;
      lock_src_q   <= SrcInstr;
      starve_q     <= '0;
      for (int i = 0; i < TagDepth; i++) tag_q[i] <= SrcInstr;
    end else begin
      cnt_q        <= cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      lock_valid_q <= lock_valid_d;
      lock_src_q   <= lock_src_d;
      starve_q     <= starve_d;
      if (issue) tag_q[wr_ptr_q] <= sel_data ? SrcData : SrcInstr;
    end
  end

  // OBI forbids withdrawing a request before it is granted.
  always @(posedge clk_i) begin
    if (rst_ni && lock_valid_q) begin
      assert (lock_src_q == SrcData ? data_req_i : instr_req_i)
        else $error("locked requester withdrew its request before grant");
    end
  end

endmodule

// File: tb/tb_cve2_mem_arbiter.sv
module tb_cve2_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [31:0] instr_rdata_o;
  logic        data_req_i, data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i, data_wdata_i;
  logic        data_gnt_o, data_rvalid_o, data_err_o;
  logic [31:0] data_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_gnt_i, mem_rvalid_i, mem_err_i;
  logic [31:0] mem_rdata_i;
  logic [1:0]  outstanding_o;

  always #5 clk = ~clk;

  cve2_mem_arbiter #(.MaxOutstanding(2), .StarveLimit(4)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
    .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
    .outstanding_o(outstanding_o)
  );

  typedef struct packed {
    logic        src;    // 0 = instr, 1 = data
    logic [31:0] rdata;
    logic        err;
  } item_t;

  item_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_reqs();
    instr_req_i = 0; instr_addr_i = 0;
    data_req_i = 0; data_we_i = 0; data_be_i = 0; data_addr_i = 0; data_wdata_i = 0;
    mem_gnt_i = 0;
  endtask

  task automatic no_resp();
    mem_rvalid_i = 0; mem_err_i = 0; mem_rdata_i = 0;
  endtask

  task automatic expect_resp(input logic src, input logic [31:0] rd, input logic err);
    item_t it;
    it.src = src; it.rdata = rd; it.err = err;
    sb.push_back(it);
  endtask

  task automatic drive_resp(output item_t it);
    if (sb.size() == 0) begin
      checks++; errors++;
      $error("FAIL scoreboard_underflow observed=0 expected=nonzero");
      it = '0;
    end else begin
      it = sb.pop_front();
    end
    mem_rvalid_i = 1; mem_rdata_i = it.rdata; mem_err_i = it.err;
  endtask

  task automatic check_resp(input string tag, input item_t it);
    chk({tag, "_instr_rvalid"}, instr_rvalid_o, !it.src);
    chk({tag, "_data_rvalid"},  data_rvalid_o,  it.src);
    chk({tag, "_instr_err"},    instr_err_o,    !it.src && it.err);
    chk({tag, "_data_err"},     data_err_o,     it.src && it.err);
    chk({tag, "_rdata"},        it.src ? data_rdata_o : instr_rdata_o, it.rdata);
  endtask

  task automatic check_no_resp(input string tag);
    chk({tag, "_instr_rvalid"}, instr_rvalid_o, 0);
    chk({tag, "_data_rvalid"},  data_rvalid_o,  0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    item_t it;
    idle_reqs();
    no_resp();
    rst_ni = 0;

    // Reset state: all outputs zero.
    #1;
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_mem_be", mem_be_o, 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_outstanding", outstanding_o, 0);
    chk("rst_instr_gnt", instr_gnt_o, 0);
    chk("rst_data_gnt", data_gnt_o, 0);
    check_no_resp("rst");
    step(); rst_ni = 1;

    // 1: single fetch, granted immediately, response next cycle.
    step();
    instr_req_i = 1; instr_addr_i = 32'h80; mem_gnt_i = 1;
    #1;
    chk("t1_mem_req", mem_req_o, 1);
    chk("t1_addr", mem_addr_o, 32'h80);
    chk("t1_be", mem_be_o, 4'hF);
    chk("t1_we", mem_we_o, 0);
    chk("t1_instr_gnt", instr_gnt_o, 1);
    chk("t1_data_gnt", data_gnt_o, 0);
    expect_resp(0, 32'h1111_0080, 0);
    step();
    idle_reqs();
    drive_resp(it);
    #1;
    chk("t1_outstanding", outstanding_o, 1);
    check_resp("t1", it);
    step(); no_resp();
    #1;
    chk("t1_drained", outstanding_o, 0);

    // 2: both request with grant held; data wins 4 times, then instr.
    for (int i = 0; i < 5; i++) begin
      step();
      instr_req_i = 1; instr_addr_i = 32'h200;
      data_req_i = 1; data_addr_i = 32'h300; data_be_i = 4'h5;
      mem_gnt_i = 1;
      if (i > 0) drive_resp(it); else no_resp();
      #1;
      chk($sformatf("t2_data_gnt%0d", i), data_gnt_o, (i < 4));
      chk($sformatf("t2_instr_gnt%0d", i), instr_gnt_o, (i == 4));
      chk($sformatf("t2_addr%0d", i), mem_addr_o, (i < 4) ? 32'h300 : 32'h200);
      if (i > 0) check_resp($sformatf("t2_resp%0d", i), it);
      if (i < 4) expect_resp(1, 32'hD000_0000 + i, 0);
      else       expect_resp(0, 32'h1000_0200, 0);
    end
    step(); idle_reqs(); drive_resp(it);
    #1; check_resp("t2_last", it);
    step(); no_resp();
    #1; chk("t2_drained", outstanding_o, 0);

    // 3: data write stalled by mem_gnt_i=0 while instr arrives.
    step();
    data_req_i = 1; data_we_i = 1; data_be_i = 4'h3; data_addr_i = 32'h100; data_wdata_i = 32'hDEAD;
    #1;
    chk("t3_addr0", mem_addr_o, 32'h100);
    chk("t3_we0", mem_we_o, 1);
    chk("t3_be0", mem_be_o, 4'h3);
    chk("t3_wdata0", mem_wdata_o, 32'hDEAD);
    chk("t3_gnt0", data_gnt_o, 0);
    for (int i = 1; i < 3; i++) begin
      step();
      instr_req_i = 1; instr_addr_i = 32'h180;
      #1;
      chk($sformatf("t3_addr%0d", i), mem_addr_o, 32'h100);
      chk($sformatf("t3_instr_gnt%0d", i), instr_gnt_o, 0);
    end
    step(); mem_gnt_i = 1;
    #1;
    chk("t3_data_gnt", data_gnt_o, 1);
    chk("t3_addr_gnt", mem_addr_o, 32'h100);
    expect_resp(1, 32'h0, 0);
    step(); data_req_i = 0; data_we_i = 0;
    #1;
    chk("t3_instr_gnt", instr_gnt_o, 1);
    chk("t3_instr_addr", mem_addr_o, 32'h180);
    expect_resp(0, 32'h2222_0180, 0);
    step(); idle_reqs(); drive_resp(it); #1; check_resp("t3_r0", it);
    step(); drive_resp(it); #1; check_resp("t3_r1", it);
    step(); no_resp();

    // 3b: a stalled instr request stays locked when data shows up.
    step();
    instr_req_i = 1; instr_addr_i = 32'h400;
    #1; chk("t3b_addr0", mem_addr_o, 32'h400);
    step();
    data_req_i = 1; data_addr_i = 32'h500; data_be_i = 4'hC;
    #1;
    chk("t3b_addr1", mem_addr_o, 32'h400);
    chk("t3b_data_gnt1", data_gnt_o, 0);
    step(); mem_gnt_i = 1;
    #1;
    chk("t3b_instr_gnt", instr_gnt_o, 1);
    chk("t3b_data_gnt2", data_gnt_o, 0);
    expect_resp(0, 32'h3333_0400, 1);
    step(); instr_req_i = 0;
    #1;
    chk("t3b_data_gnt", data_gnt_o, 1);
    chk("t3b_addr3", mem_addr_o, 32'h500);
    expect_resp(1, 32'h4444_0500, 0);
    step(); idle_reqs(); drive_resp(it); #1; check_resp("t3b_r0", it);
    step(); drive_resp(it); #1; check_resp("t3b_r1", it);
    step(); no_resp();

    // 4: fill MaxOutstanding, then one response reopens issue next cycle.
    step(); instr_req_i = 1; instr_addr_i = 32'h10; mem_gnt_i = 1;
    #1; chk("t4_gnt0", instr_gnt_o, 1); expect_resp(0, 32'h10, 0);
    step(); instr_addr_i = 32'h14;
    #1; chk("t4_gnt1", instr_gnt_o, 1); expect_resp(0, 32'h14, 0);
    step(); instr_addr_i = 32'h18;
    #1;
    chk("t4_full_req", mem_req_o, 0);
    chk("t4_full_gnt", instr_gnt_o, 0);
    chk("t4_full_cnt", outstanding_o, 2);
    step(); drive_resp(it);
    #1;
    chk("t4_pop_req", mem_req_o, 0);
    check_resp("t4_r0", it);
    step(); no_resp();
    #1;
    chk("t4_resume_req", mem_req_o, 1);
    chk("t4_resume_gnt", instr_gnt_o, 1);
    chk("t4_resume_cnt", outstanding_o, 1);
    expect_resp(0, 32'h18, 0);
    step(); idle_reqs(); drive_resp(it); #1; check_resp("t4_r1", it);
    step(); drive_resp(it); #1; check_resp("t4_r2", it);
    step(); no_resp();
    #1; chk("t4_drained", outstanding_o, 0);

    // 5: data then instr; error on the first response only.
    step(); data_req_i = 1; data_addr_i = 32'h600; data_be_i = 4'hF; mem_gnt_i = 1;
    #1; chk("t5_data_gnt", data_gnt_o, 1); expect_resp(1, 32'h5555_0600, 1);
    step(); data_req_i = 0; instr_req_i = 1; instr_addr_i = 32'h700;
    #1; chk("t5_instr_gnt", instr_gnt_o, 1); expect_resp(0, 32'h6666_0700, 0);
    step(); idle_reqs(); drive_resp(it); #1; check_resp("t5_r0", it);
    step(); drive_resp(it); #1; check_resp("t5_r1", it);
    step(); no_resp();

    // 6: reset with one outstanding, then a stray response.
    step(); instr_req_i = 1; instr_addr_i = 32'h900; mem_gnt_i = 1;
    #1; chk("t6_gnt", instr_gnt_o, 1);
    step(); idle_reqs();
    #1; chk("t6_cnt_before", outstanding_o, 1);
    #2; rst_ni = 0;
    #1; chk("t6_cnt_async", outstanding_o, 0);
    step(); rst_ni = 1;
    step(); mem_rvalid_i = 1; mem_rdata_i = 32'hBAD0_0900;
    #1;
    check_no_resp("t6_stray");
    chk("t6_cnt_stray", outstanding_o, 0);
    step(); no_resp();
    #1; chk("t6_cnt_after", outstanding_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
